// File: rtl/gb_video_scaler_if.sv
// Port bundle for the GB video scaler: pixel capture, palette/border configuration
// and the timed RGB output towards the DVI encoder.
interface gb_video_scaler_if #(
  parameter int COLOR_W = 8
);
  logic                   pix_ce;
  logic                   in_we;
  logic [7:0]             in_x;
  logic [7:0]             in_y;
  logic [1:0]             in_pixel;
  logic                   lcd_on;
  logic [3*COLOR_W-1:0]   border;
  logic                   pal_we;
  logic [1:0]             pal_idx;
  logic [3*COLOR_W-1:0]   pal_data;
  logic [3*COLOR_W-1:0]   color;
  logic                   hsync;
  logic                   vsync;
  logic                   blank_b;
  logic                   frame_start;

  modport master (
    output pix_ce, in_we, in_x, in_y, in_pixel, lcd_on, border, pal_we, pal_idx, pal_data,
    input  color, hsync, vsync, blank_b, frame_start
  );

  modport slave (
    input  pix_ce, in_we, in_x, in_y, in_pixel, lcd_on, border, pal_we, pal_idx, pal_data,
    output color, hsync, vsync, blank_b, frame_start
  );
endinterface

// File: rtl/gb_video_scaler.sv
// Game Boy frame capture plus integer-upscaled, centred display timing generator
// with border fill, 4-entry RGB palette and LCD-off blanking.
module gb_video_scaler #(
  parameter int SRC_W    = 160,
  parameter int SRC_H    = 144,
  parameter int SCALE    = 3,
  parameter int X_OFF    = 80,
  parameter int Y_OFF    = 24,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = 8
) (
  input logic             clock,
  input logic             reset,
  gb_video_scaler_if.slave vid
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int WIN_W = SRC_W * SCALE;
  localparam int WIN_H = SRC_H * SCALE;
  localparam int DEPTH = SRC_W * SRC_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int SXW   = $clog2(SRC_W + 1);
  localparam int SYW   = $clog2(SRC_H + 1);
  localparam int SUBW  = $clog2(SCALE + 1);
  localparam int CW3   = 3 * COLOR_W;

  localparam logic [CW3-1:0] PAL_WHITE = '1;
  localparam logic [CW3-1:0] PAL_DARK  = PAL_WHITE / CW3'(3);
  localparam logic [CW3-1:0] PAL_LIGHT = PAL_DARK << 1;

  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [SXW-1:0]  sx;
  logic [SYW-1:0]  sy;
  logic [SUBW-1:0] sx_sub;
  logic [SUBW-1:0] sy_sub;

  logic            h_last, v_last, h_win, v_win, visible, hs_act, vs_act, at_origin;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic            wr_ok;

  logic [1:0]      mem [DEPTH];
  logic [CW3-1:0]  pal [4];

  logic            s1_vis, s1_win, s1_hs, s1_vs, s1_fs;
  logic [1:0]      s1_pix;
  logic [CW3-1:0]  pix_color;

  logic [CW3-1:0]  color_q;
  logic            hsync_q, vsync_q, blank_q, fs_q;

  always_comb begin
    h_last    = (int'(h_cnt) == H_TOT - 1);
    v_last    = (int'(v_cnt) == V_TOT - 1);
    h_win     = (int'(h_cnt) >= X_OFF) && (int'(h_cnt) < X_OFF + WIN_W);
    v_win     = (int'(v_cnt) >= Y_OFF) && (int'(v_cnt) < Y_OFF + WIN_H);
    visible   = (int'(h_cnt) < H_ACT) && (int'(v_cnt) < V_ACT);
    hs_act    = (int'(h_cnt) >= H_ACT + H_FP) && (int'(h_cnt) < H_ACT + H_FP + H_SYNC);
    vs_act    = (int'(v_cnt) >= V_ACT + V_FP) && (int'(v_cnt) < V_ACT + V_FP + V_SYNC);
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    // Outside the window sx/sy may sit one past the last column/line; keep the read in range.
    rd_addr   = (h_win && v_win) ? AW'(int'(sy) * SRC_W + int'(sx)) : '0;
    wr_ok     = vid.in_we && (int'(vid.in_x) < SRC_W) && (int'(vid.in_y) < SRC_H);
    wr_addr   = AW'(int'(vid.in_y) * SRC_W + int'(vid.in_x));
  end

  // Raster counters and source-coordinate sub-counters; the sub-counters are
  // cleared whenever the raster is outside the window so each window starts at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      sx     <= '0;
      sx_sub <= '0;
      sy     <= '0;
      sy_sub <= '0;
    end else if (vid.pix_ce) begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;

      if (h_win) begin
        if (sx_sub == SUBW'(SCALE - 1)) begin
          sx_sub <= '0;
          sx     <= sx + 1'b1;
        end else begin
          sx_sub <= sx_sub + 1'b1;
        end
      end else begin
        sx     <= '0;
        sx_sub <= '0;
      end

      if (h_last) begin
        if (v_win) begin
          if (sy_sub == SUBW'(SCALE - 1)) begin
            sy_sub <= '0;
            sy     <= sy + 1'b1;
          end else begin
            sy_sub <= sy_sub + 1'b1;
          end
        end else begin
          sy     <= '0;
          sy_sub <= '0;
        end
      end
    end
  end

  // Frame buffer is never cleared; a same-address read returns the pre-write data.
  always_ff @(posedge clock) begin
    if (wr_ok)
      mem[wr_addr] <= vid.in_pixel;
    if (vid.pix_ce)
      s1_pix <= mem[rd_addr];
  end

  always_comb begin
    pix_color = '0;
    if (!s1_vis)
      pix_color = '0;
    else if (!s1_win)
      pix_color = vid.border;
    else if (!vid.lcd_on)
      pix_color = pal[0];
    else
      pix_color = pal[s1_pix];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pal[0]  <= PAL_WHITE;
      pal[1]  <= PAL_LIGHT;
      pal[2]  <= PAL_DARK;
      pal[3]  <= '0;
      s1_vis  <= 1'b0;
      s1_win  <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_fs   <= 1'b0;
      color_q <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      if (vid.pal_we)
        pal[vid.pal_idx] <= vid.pal_data;
      if (vid.pix_ce) begin
        s1_vis  <= visible;
        s1_win  <= h_win && v_win;
        s1_hs   <= hs_act;
        s1_vs   <= vs_act;
        s1_fs   <= at_origin;
        color_q <= pix_color;
        hsync_q <= s1_hs ? SYNC_POL : ~SYNC_POL;
        vsync_q <= s1_vs ? SYNC_POL : ~SYNC_POL;
        blank_q <= s1_vis;
        fs_q    <= s1_fs;
      end else begin
        fs_q    <= 1'b0;
      end
    end
  end

  assign vid.color       = color_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.blank_b     = blank_q;
  assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_gb_video_scaler.sv
// Directed bench for gb_video_scaler on a reduced raster (20x12 total, 4x3 source, 2x scale).
module tb_gb_video_scaler;

  localparam int HT = 20;
  localparam int VT = 12;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BORDER = 24'h0A0B0C;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  gb_video_scaler_if #(.COLOR_W(8)) vid ();

  gb_video_scaler #(
    .SRC_W(4), .SRC_H(3), .SCALE(2), .X_OFF(2), .Y_OFF(1),
    .H_ACT(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .COLOR_W(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .vid   (vid.master)
  );

  int checks = 0;
  int passes = 0;
  logic [1:0]  m_mem [12];
  logic [23:0] m_pal [4];
  logic        m_lcd;

  function automatic logic [23:0] exp_color(int h, int v);
    if (h >= 12 || v >= 8) return 24'h0;
    if (h < 2 || h >= 10 || v < 1 || v >= 7) return BORDER;
    if (!m_lcd) return m_pal[0];
    return m_pal[m_mem[((v - 1) / 2) * 4 + (h - 2) / 2]];
  endfunction

  // {hsync, vsync, blank_b, frame_start}
  function automatic logic [3:0] exp_sync(int h, int v);
    return {!(h >= 14 && h < 17), !(v >= 9 && v < 11), (h < 12 && v < 8), (h == 0 && v == 0)};
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    vid.pix_ce = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_pal[0] = 24'hFFFFFF; m_pal[1] = 24'hAAAAAA; m_pal[2] = 24'h555555; m_pal[3] = 24'h000000;
  endtask

  task automatic wr_px(input int x, input int y, input logic [1:0] p);
    vid.in_we = 1'b1; vid.in_x = 8'(x); vid.in_y = 8'(y); vid.in_pixel = p;
    tick();
    vid.in_we = 1'b0;
  endtask

  // mode < 0: checkerboard (x+y)%4, otherwise every pixel = mode
  task automatic fill(input int mode);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) begin
        m_mem[y * 4 + x] = (mode < 0) ? 2'((x + y) % 4) : 2'(mode);
        wr_px(x, y, m_mem[y * 4 + x]);
      end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (vid.color !== 24'h0) $display("FAIL reset_color got %h want 000000", vid.color); else passes++;
    checks++; if (vid.blank_b !== 1'b0) $display("FAIL reset_blank got %b want 0", vid.blank_b); else passes++;
    checks++; if (vid.frame_start !== 1'b0) $display("FAIL reset_fs got %b want 0", vid.frame_start); else passes++;
    checks++; if (vid.hsync !== 1'b1) $display("FAIL reset_hsync got %b want 1", vid.hsync); else passes++;
    checks++; if (vid.vsync !== 1'b1) $display("FAIL reset_vsync got %b want 1", vid.vsync); else passes++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_frame();
    int p, h, v, fs_cnt, blank_cnt, hs_lo;
    fs_cnt = 0; blank_cnt = 0; hs_lo = 0;
    do_reset();
    m_lcd = 1'b1; vid.lcd_on = 1'b1;
    fill(-1);
    vid.pix_ce = 1'b1;
    for (int n = 1; n <= FRAME + 1; n++) begin
      tick();
      if (vid.frame_start) fs_cnt++;
      if (n >= 2) begin
        p = n - 2; h = p % HT; v = p / HT;
        if (vid.blank_b) blank_cnt++;
        if (!vid.hsync) hs_lo++;
        checks++;
        if (vid.color !== exp_color(h, v))
          $display("FAIL frame_color h=%0d v=%0d got %h want %h", h, v, vid.color, exp_color(h, v));
        else passes++;
        checks++;
        if ({vid.hsync, vid.vsync, vid.blank_b, vid.frame_start} !== exp_sync(h, v))
          $display("FAIL frame_sync h=%0d v=%0d got %b want %b", h, v,
                   {vid.hsync, vid.vsync, vid.blank_b, vid.frame_start}, exp_sync(h, v));
        else passes++;
      end
    end
    checks++; if (fs_cnt !== 1) $display("FAIL frame_start_count got %0d want 1", fs_cnt); else passes++;
    checks++; if (blank_cnt !== 96) $display("FAIL blank_count got %0d want 96", blank_cnt); else passes++;
    checks++; if (hs_lo !== 36) $display("FAIL hsync_low_count got %0d want 36", hs_lo); else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    vid.pix_ce = 1'b1;
    tick(); tick();
    checks++; if (vid.frame_start !== 1'b1) $display("FAIL stall_fs_on got %b want 1", vid.frame_start); else passes++;
    vid.pix_ce = 1'b0;
    tick();
    checks++; if (vid.frame_start !== 1'b0) $display("FAIL stall_fs_pulse got %b want 0", vid.frame_start); else passes++;
    checks++; if (vid.blank_b !== 1'b1) $display("FAIL stall_blank_hold got %b want 1", vid.blank_b); else passes++;
    checks++; if (vid.color !== BORDER) $display("FAIL stall_color_hold got %h want %h", vid.color, BORDER); else passes++;
    vid.pix_ce = 1'b1;
    tick();
    checks++; if (vid.frame_start !== 1'b0) $display("FAIL stall_fs_resume got %b want 0", vid.frame_start); else passes++;
  endtask

  task automatic test_lcd_off();
    int p, h, v;
    do_reset();
    m_lcd = 1'b0; vid.lcd_on = 1'b0;
    fill(3);
    vid.pix_ce = 1'b1;
    for (int n = 1; n <= FRAME + 1; n++) begin
      tick();
      if (n >= 2) begin
        p = n - 2; h = p % HT; v = p / HT;
        checks++;
        if (vid.color !== exp_color(h, v))
          $display("FAIL lcd_off_color h=%0d v=%0d got %h want %h", h, v, vid.color, exp_color(h, v));
        else passes++;
      end
    end
  endtask

  task automatic test_palette_write();
    int p, h, v, seen_new, seen_old;
    seen_new = 0; seen_old = 0;
    do_reset();
    m_lcd = 1'b1; vid.lcd_on = 1'b1;
    fill(3);
    vid.pix_ce = 1'b1;
    for (int n = 1; n <= FRAME + 1; n++) begin
      if (n == 100) begin
        vid.pal_we = 1'b1; vid.pal_idx = 2'd3; vid.pal_data = 24'h123456;
      end
      tick();
      if (n >= 2) begin
        p = n - 2; h = p % HT; v = p / HT;
        if (vid.color === 24'h123456) seen_new++;
        if (vid.color === 24'h000000 && vid.blank_b === 1'b1) seen_old++;
        checks++;
        if (vid.color !== exp_color(h, v))
          $display("FAIL pal_color h=%0d v=%0d got %h want %h", h, v, vid.color, exp_color(h, v));
        else passes++;
      end
      if (n == 100) begin
        vid.pal_we = 1'b0;
        m_pal[3] = 24'h123456;
      end
    end
    checks++; if (seen_new == 0) $display("FAIL pal_new_seen got %0d want >0", seen_new); else passes++;
    checks++; if (seen_old == 0) $display("FAIL pal_old_seen got %0d want >0", seen_old); else passes++;
  endtask

  task automatic test_oob_write();
    int p, h, v;
    do_reset();
    m_lcd = 1'b1; vid.lcd_on = 1'b1;
    fill(-1);
    wr_px(4, 0, 2'd1);
    wr_px(4, 1, 2'd1);
    wr_px(0, 3, 2'd1);
    wr_px(255, 2, 2'd1);
    wr_px(3, 2, 2'd0);
    m_mem[11] = 2'd0;
    vid.pix_ce = 1'b1;
    for (int n = 1; n <= FRAME + 1; n++) begin
      tick();
      if (n >= 2) begin
        p = n - 2; h = p % HT; v = p / HT;
        checks++;
        if (vid.color !== exp_color(h, v))
          $display("FAIL oob_color h=%0d v=%0d got %h want %h", h, v, vid.color, exp_color(h, v));
        else passes++;
      end
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    m_lcd = 1'b1; vid.lcd_on = 1'b1;
    vid.pix_ce = 1'b1;
    for (int n = 1; n <= 103; n++) tick();
    checks++; if (vid.color !== BORDER) $display("FAIL mid_pre_color got %h want %h", vid.color, BORDER); else passes++;
    checks++; if (vid.blank_b !== 1'b1) $display("FAIL mid_pre_blank got %b want 1", vid.blank_b); else passes++;
    #2 reset = 1'b1;
    #1;
    checks++; if (vid.color !== 24'h0) $display("FAIL mid_rst_color got %h want 000000", vid.color); else passes++;
    checks++; if (vid.blank_b !== 1'b0) $display("FAIL mid_rst_blank got %b want 0", vid.blank_b); else passes++;
    checks++; if ({vid.hsync, vid.vsync} !== 2'b11) $display("FAIL mid_rst_sync got %b want 11", {vid.hsync, vid.vsync}); else passes++;
    @(negedge clock);
    reset = 1'b0;
    tick();
    checks++; if (vid.frame_start !== 1'b0) $display("FAIL mid_fs_tick1 got %b want 0", vid.frame_start); else passes++;
    tick();
    checks++; if (vid.frame_start !== 1'b1) $display("FAIL mid_fs_tick2 got %b want 1", vid.frame_start); else passes++;
    checks++; if (vid.color !== BORDER) $display("FAIL mid_origin_color got %h want %h", vid.color, BORDER); else passes++;
    tick();
    checks++; if (vid.frame_start !== 1'b0) $display("FAIL mid_fs_tick3 got %b want 0", vid.frame_start); else passes++;
  endtask

  initial begin
    vid.pix_ce = 1'b0; vid.in_we = 1'b0; vid.in_x = '0; vid.in_y = '0; vid.in_pixel = '0;
    vid.lcd_on = 1'b1; vid.border = BORDER;
    vid.pal_we = 1'b0; vid.pal_idx = '0; vid.pal_data = '0;
    m_lcd = 1'b1;
    test_reset();
    test_frame();
    test_stall();
    test_lcd_off();
    test_palette_write();
    test_oob_write();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
